// File: rtl/rr_bus_load_arbiter.sv
// Round-robin arbiter loading one registered output word from NREQ requesters; REQ at edge k -> GNT/OUT_VALID in cycle k..k+1.
// Backpressure: a held word stays stable while OUT_READY=0; optional watchdog drops it after TIMEOUT stalled cycles and sets sticky ERR.
module rr_bus_load_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int SW      = 2,
   parameter int TIMEOUT = 0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*DW-1:0] DATA,
   output logic [NREQ-1:0]    GNT,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [DW-1:0]      OUT_DATA,
   output logic [SW-1:0]      OUT_SRC,
   output logic               ERR
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state;
   logic [SW-1:0]   last;
   logic [CW-1:0]   stall_cnt;
   logic [NREQ-1:0] elig;
   logic [SW-1:0]   win;
   logic [DW-1:0]   win_dat;
   logic            win_vld;
   logic            capture;

   // A requester just granted is masked for one cycle so it can drop REQ.
   assign elig = REQ & ~GNT;

   always_comb begin
      int idx;
      win     = '0;
      win_dat = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last) + k) % NREQ;
         if (!win_vld && elig[idx]) begin
            win_vld = 1'b1;
            win     = SW'(idx);
            win_dat = DATA[idx*DW +: DW];
         end
      end
   end

   assign capture = win_vld && ((state == IDLE) || OUT_READY);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         GNT       <= '0;
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_SRC   <= '0;
         ERR       <= 1'b0;
         stall_cnt <= '0;
         last      <= SW'(NREQ - 1);
      end else begin
         GNT <= '0;
         if (capture) begin
            state     <= HOLD;
            OUT_VALID <= 1'b1;
            OUT_DATA  <= win_dat;
            OUT_SRC   <= win;
            last      <= win;
            GNT       <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            stall_cnt <= '0;
         end else if (state == HOLD) begin
            if (OUT_READY) begin
               state     <= IDLE;
               OUT_VALID <= 1'b0;
            end else if ((TIMEOUT > 0) && (stall_cnt == TLAST)) begin
               // Downstream stuck too long: discard the word and flag it.
               state     <= IDLE;
               OUT_VALID <= 1'b0;
               ERR       <= 1'b1;
               stall_cnt <= '0;
            end else if (stall_cnt != TMAX) begin
               stall_cnt <= stall_cnt + 1'b1;
            end
         end
      end
   end

endmodule
